// File: rtl/seawolf_sample_mixer.sv
// seawolf_sample_mixer: multi-channel PCM player with round-robin sample fetch and saturating stereo mix
module seawolf_sample_mixer #(
    parameter int                       NUM_CH    = 4,
    parameter int                       ADDR_W    = 24,
    parameter logic [7:0]               PORT_ADDR = 8'h10,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE   = '0,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_LEN    = '0,
    parameter logic [NUM_CH-1:0]        LOOP_MASK = '0,
    parameter logic [NUM_CH-1:0]        PAN_L     = '1,
    parameter logic [NUM_CH-1:0]        PAN_R     = '1
) (
    input  logic              CLK,
    input  logic              I_RESET,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_data,
    input  logic              I_IORQ_L,
    input  logic              I_WR_L,
    input  logic              I_CPU_ENA,
    input  logic              ENA,
    input  logic              s_enable,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_read,
    input  logic [15:0]       s_data,
    input  logic              s_ready,
    output logic [15:0]       audio_out_l,
    output logic [15:0]       audio_out_r,
    output logic [NUM_CH-1:0] underrun
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int AW = 16 + $clog2(NUM_CH);
    localparam logic signed [AW-1:0] SMAX = AW'(32767);
    localparam logic signed [AW-1:0] SMIN = AW'(-32768);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state;
    logic [NUM_CH-1:0]   trig, active, need, stop;
    logic [ADDR_W-1:0]   ptr [NUM_CH];
    logic [15:0]         sample [NUM_CH];
    logic [CW-1:0]       cur, last, sel;
    logic                discard, wr_q, wr_sel, wr_pulse, found;
    logic [NUM_CH-1:0]   rise, elig, play;
    logic [ADDR_W-1:0]   cur_base, nxt, lim;
    logic signed [AW-1:0] sum_l, sum_r;
    logic                unused_bits;

    assign unused_bits = ^{cpu_addr[15:8], cpu_data};
    // Edge-detect the qualified strobe so a multi-cycle I/O write triggers once
    assign wr_sel   = !I_IORQ_L && !I_WR_L && cpu_addr[7:0] == PORT_ADDR;
    assign wr_pulse = I_CPU_ENA && wr_sel && !wr_q;
    assign rise     = wr_pulse ? cpu_data[NUM_CH-1:0] & ~trig : '0;
    assign elig     = active & need;
    assign play     = active | stop;
    assign cur_base = CH_BASE[int'(cur)*ADDR_W +: ADDR_W];
    assign lim      = cur_base + CH_LEN[int'(cur)*ADDR_W +: ADDR_W];
    assign nxt      = ptr[cur] + ADDR_W'(2);

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            automatic int j;
            j = (int'(last) + k) % NUM_CH;
            if (!found && elig[j]) begin
                found = 1'b1;
                sel   = CW'(j);
            end
        end
    end

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (PAN_L[n] && play[n]) sum_l = sum_l + AW'($signed(sample[n]));
            if (PAN_R[n] && play[n]) sum_r = sum_r + AW'($signed(sample[n]));
        end
    end

    function automatic logic [15:0] sat(input logic signed [AW-1:0] v);
        return v > SMAX ? 16'h7fff : v < SMIN ? 16'h8000 : v[15:0];
    endfunction

    always_ff @(posedge CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state       <= IDLE;
            trig        <= '0;
            active      <= '0;
            need        <= '0;
            stop        <= '0;
            underrun    <= '0;
            cur         <= '0;
            last        <= CW'(NUM_CH - 1);
            discard     <= 1'b0;
            wr_q        <= 1'b0;
            s_read      <= 1'b0;
            s_addr      <= '0;
            audio_out_l <= '0;
            audio_out_r <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                ptr[n]    <= '0;
                sample[n] <= '0;
            end
        end else begin
            if (I_CPU_ENA) wr_q <= wr_sel;
            if (wr_pulse) trig <= cpu_data[NUM_CH-1:0];
            if (ENA) begin
                audio_out_l <= sat(sum_l);
                audio_out_r <= sat(sum_r);
                for (int n = 0; n < NUM_CH; n++) begin
                    if (active[n]) begin
                        if (need[n]) underrun[n] <= 1'b1;
                        need[n] <= 1'b1;
                    end
                    if (stop[n]) begin
                        sample[n] <= '0;
                        stop[n]   <= 1'b0;
                    end
                end
            end
            if (state == IDLE) begin
                if (s_enable && found) begin
                    cur     <= sel;
                    s_addr  <= ptr[sel];
                    s_read  <= 1'b1;
                    discard <= rise[sel];
                    state   <= WAIT;
                end
            end else begin
                if (rise[cur]) discard <= 1'b1;
                if (s_ready) begin
                    s_read  <= 1'b0;
                    last    <= cur;
                    discard <= 1'b0;
                    state   <= IDLE;
                    // A retrigger during the read makes the returned word stale
                    if (!(discard || rise[cur])) begin
                        sample[cur] <= s_data;
                        need[cur]   <= 1'b0;
                        if (nxt != lim) ptr[cur] <= nxt;
                        else if (LOOP_MASK[cur] && trig[cur]) ptr[cur] <= cur_base;
                        else begin
                            active[cur] <= 1'b0;
                            stop[cur]   <= 1'b1;
                        end
                    end
                end
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (rise[n]) begin
                    active[n]   <= 1'b1;
                    need[n]     <= 1'b1;
                    stop[n]     <= 1'b0;
                    underrun[n] <= 1'b0;
                    ptr[n]      <= CH_BASE[n*ADDR_W +: ADDR_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_seawolf_sample_mixer.sv
// tb_seawolf_sample_mixer: directed scoreboard bench for the sample mixer
module tb_seawolf_sample_mixer;
    logic        CLK = 0, I_RESET = 1;
    logic [15:0] cpu_addr = 0;
    logic [7:0]  cpu_data = 0;
    logic        I_IORQ_L = 1, I_WR_L = 1, I_CPU_ENA = 1, ENA = 0, s_enable = 1;
    logic [23:0] s_addr;
    logic        s_read;
    logic [15:0] s_data = 0;
    logic        s_ready = 0;
    logic [15:0] audio_out_l, audio_out_r;
    logic [3:0]  underrun;

    int          n_cmp = 0, n_err = 0;
    int          dly = 0;
    bit          hold = 0, mode = 0;
    logic [15:0] fix = 0;
    logic [31:0] q[$];

    seawolf_sample_mixer #(
        .NUM_CH(4), .ADDR_W(24), .PORT_ADDR(8'h10),
        .CH_BASE({24'h000400, 24'h000300, 24'h000200, 24'h000100}),
        .CH_LEN({24'd4, 24'd4, 24'd6, 24'd8}),
        .LOOP_MASK(4'b0010), .PAN_L(4'b1111), .PAN_R(4'b1011)
    ) dut (
        .CLK(CLK), .I_RESET(I_RESET), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .I_IORQ_L(I_IORQ_L), .I_WR_L(I_WR_L), .I_CPU_ENA(I_CPU_ENA), .ENA(ENA),
        .s_enable(s_enable), .s_addr(s_addr), .s_read(s_read), .s_data(s_data),
        .s_ready(s_ready), .audio_out_l(audio_out_l), .audio_out_r(audio_out_r),
        .underrun(underrun)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge CLK);
        cpu_addr = 16'hAB10;
        cpu_data = d;
        I_IORQ_L = 0;
        I_WR_L   = 0;
        repeat (3) @(negedge CLK);
        I_IORQ_L = 1;
        I_WR_L   = 1;
        cpu_addr = 0;
    endtask

    task automatic tick();
        @(negedge CLK);
        ENA = 1;
        @(negedge CLK);
        ENA = 0;
    endtask

    task automatic tick_chk(input string tag, input logic [15:0] l, input logic [15:0] r);
        tick();
        chk({tag, "_l"}, 32'(audio_out_l), 32'(l));
        chk({tag, "_r"}, 32'(audio_out_r), 32'(r));
    endtask

    task automatic wait_idle();
        automatic int t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while ((q.size() != 0 || s_read) && t < 200);
        chk("idle", 32'(t < 200), 32'd1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        I_RESET = 1;
        @(negedge CLK);
        I_RESET = 0;
    endtask

    // Sample memory: checks each request against the queue, acks after dly cycles
    initial begin
        int          cnt;
        bit          prev;
        logic [31:0] e;
        cnt  = 0;
        prev = 0;
        forever begin
            @(negedge CLK);
            s_ready = 0;
            if (prev) chk("req_gap", 32'(s_read), 32'd0);
            prev = 0;
            if (!s_read) cnt = 0;
            else begin
                if (cnt == 0) begin
                    if (q.size() != 0) e = q.pop_front();
                    else e = 32'hFFFF_FFFF;
                    chk("fetch_addr", 32'(s_addr), e);
                end
                if (cnt >= dly && !hold) begin
                    s_ready = 1;
                    s_data  = mode ? fix : {s_addr[11:0], 4'h0};
                    cnt     = 0;
                    prev    = 1;
                end else cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_read", 32'(s_read), 32'd0);
        chk("rst_addr", 32'(s_addr), 32'd0);
        chk("rst_l", 32'(audio_out_l), 32'd0);
        chk("rst_r", 32'(audio_out_r), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        I_RESET = 0;

        // Reset while a read is outstanding
        hold = 1;
        q.push_back(32'h100);
        wr(8'h01);
        begin
            automatic int t = 0;
            while (!s_read && t < 20) begin
                @(negedge CLK);
                t++;
            end
        end
        chk("midfetch_addr", 32'(s_addr), 32'h100);
        @(negedge CLK);
        I_RESET = 1;
        #1;
        chk("midfetch_read", 32'(s_read), 32'd0);
        chk("midfetch_saddr", 32'(s_addr), 32'd0);
        hold = 0;
        @(negedge CLK);
        I_RESET = 0;

        // Single channel plays its four words then falls silent
        q.push_back(32'h100);
        wr(8'h01);
        wait_idle();
        q.push_back(32'h102);
        tick_chk("c0_w0", 16'h1000, 16'h1000);
        wait_idle();
        q.push_back(32'h104);
        tick_chk("c0_w1", 16'h1020, 16'h1020);
        wait_idle();
        q.push_back(32'h106);
        tick_chk("c0_w2", 16'h1040, 16'h1040);
        wait_idle();
        tick_chk("c0_w3", 16'h1060, 16'h1060);
        repeat (4) @(negedge CLK);
        tick_chk("c0_end", 16'h0000, 16'h0000);
        chk("c0_underrun", 32'(underrun), 32'd0);
        do_reset();

        // All channels at once with slow memory, round-robin order
        dly = 3;
        q.push_back(32'h100); q.push_back(32'h200); q.push_back(32'h300); q.push_back(32'h400);
        wr(8'h0F);
        wait_idle();
        chk("all_underrun", 32'(underrun), 32'd0);
        q.push_back(32'h102); q.push_back(32'h202); q.push_back(32'h302); q.push_back(32'h402);
        tick_chk("all_mix", 16'h7FFF, 16'h7000);
        wait_idle();
        chk("all_underrun2", 32'(underrun), 32'd0);
        do_reset();

        // Positive and negative saturation
        dly  = 0;
        mode = 1;
        fix  = 16'h7000;
        q.push_back(32'h100); q.push_back(32'h200); q.push_back(32'h300); q.push_back(32'h400);
        wr(8'h0F);
        wait_idle();
        fix = 16'h9000;
        q.push_back(32'h102); q.push_back(32'h202); q.push_back(32'h302); q.push_back(32'h402);
        tick_chk("sat_pos", 16'h7FFF, 16'h7FFF);
        wait_idle();
        q.push_back(32'h104); q.push_back(32'h204);
        tick_chk("sat_neg", 16'h8000, 16'h8000);
        wait_idle();
        mode = 0;
        do_reset();

        // Looping channel wraps while held, stops at end once released
        q.push_back(32'h200);
        wr(8'h02);
        wait_idle();
        q.push_back(32'h202);
        tick_chk("loop_w0", 16'h2000, 16'h2000);
        wait_idle();
        q.push_back(32'h204);
        tick_chk("loop_w1", 16'h2020, 16'h2020);
        wait_idle();
        q.push_back(32'h200);
        tick_chk("loop_w2", 16'h2040, 16'h2040);
        wait_idle();
        wr(8'h00);
        q.push_back(32'h202);
        tick_chk("loop_w0b", 16'h2000, 16'h2000);
        wait_idle();
        q.push_back(32'h204);
        tick_chk("loop_w1b", 16'h2020, 16'h2020);
        wait_idle();
        tick_chk("loop_w2b", 16'h2040, 16'h2040);
        repeat (4) @(negedge CLK);
        tick_chk("loop_end", 16'h0000, 16'h0000);
        do_reset();

        // Stalled memory across ticks: sticky underrun, repeated sample
        q.push_back(32'h400);
        wr(8'h08);
        wait_idle();
        hold = 1;
        q.push_back(32'h402);
        tick_chk("ur_t0", 16'h4000, 16'h4000);
        chk("ur_none", 32'(underrun), 32'd0);
        repeat (5) @(negedge CLK);
        tick_chk("ur_t1", 16'h4000, 16'h4000);
        chk("ur_set", 32'(underrun), 32'h8);
        repeat (5) @(negedge CLK);
        tick_chk("ur_t2", 16'h4000, 16'h4000);
        chk("ur_sticky", 32'(underrun), 32'h8);
        hold = 0;
        wait_idle();
        chk("ur_after_fetch", 32'(underrun), 32'h8);
        wr(8'h00);
        q.push_back(32'h400);
        wr(8'h08);
        chk("ur_cleared", 32'(underrun), 32'd0);
        wait_idle();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seawolf_sample_mixer.md
Name: seawolf_sample_mixer

Overview:
- Parametrised successor to the single-path Seawolf sample player.
- Plays up to NUM_CH 16-bit signed PCM samples at once. Samples are fetched from external sample memory (SDRAM or DDRAM, same s_* handshake) through one round-robin fetch engine.
- Channels are triggered by CPU I/O writes. Channels flagged in LOOP_MASK repeat while their trigger bit stays set.
- Output is a saturating stereo mix with a per-channel pan setting. Sits between the Z80 I/O bus and the audio output mux.

Parameters:
NUM_CH, 4, number of sample channels (1..8)
ADDR_W, 24, sample memory byte-address width
PORT_ADDR, 8'h10, I/O port (cpu_addr[7:0]) holding the trigger bits
CH_BASE, 0, packed NUM_CH*ADDR_W start byte address per channel (even)
CH_LEN, 0, packed NUM_CH*ADDR_W length in bytes per channel (even, nonzero)
LOOP_MASK, 0, bit n=1: channel n loops while its trigger bit is held
PAN_L, all ones, bit n=1: channel n feeds the left output
PAN_R, all ones, bit n=1: channel n feeds the right output

Ports:
- CLK  in  1  system clock
- I_RESET  in  1  asynchronous active-high reset
- cpu_addr  in  16  Z80 address bus
- cpu_data  in  8  Z80 data-out bus
- I_IORQ_L  in  1  Z80 IORQ, active low
- I_WR_L  in  1  Z80 WR, active low
- I_CPU_ENA  in  1  CPU clock enable; bus sampled only when high
- ENA  in  1  sample-rate strobe, one CLK wide
- s_enable  in  1  sample memory ready for use (samples loaded)
- s_addr  out  ADDR_W  sample memory byte address
- s_read  out  1  read request, held until s_ready
- s_data  in  16  sample word, valid when s_ready=1
- s_ready  in  1  one-cycle read acknowledge
- audio_out_l  out  16  signed left mix
- audio_out_r  out  16  signed right mix
- underrun  out  NUM_CH  sticky per-channel "fetch missed tick" flags

Behaviour:
- Reset (async, immediate):
  - trig register, active, need, ptr, sample, underrun and both audio outputs = 0.
  - s_read = 0, s_addr = 0, FSM = IDLE.
- Port write:
  - Detected when I_CPU_ENA & !I_IORQ_L & !I_WR_L & cpu_addr[7:0]==PORT_ADDR.
  - Act once per I/O cycle: edge-detect the qualified strobe.
  - Latch cpu_data[NUM_CH-1:0] into trig. Bits above NUM_CH are ignored.
  - Rising bit n (0->1): active[n]=1, ptr[n]=CH_BASE[n], need[n]=1, underrun[n] cleared. This retriggers a channel already playing.
  - Falling bit n: no action unless LOOP_MASK[n]. A looped channel stops at its next end of sample.
- Tick (ENA=1), for each active channel n:
  - If need[n] is still 1, set underrun[n] and keep the old sample (repeat).
  - Set need[n]=1.
  - The mix registers on the same edge from the pre-tick sample values.
- Fetch FSM:
  - IDLE: if s_enable, scan from last_served+1 round-robin for a channel with active & need. If one is found, drive s_addr=ptr[n], s_read=1, go to WAIT.
  - WAIT: hold s_read and s_addr stable. On s_ready: sample[n]=s_data, need[n]=0, ptr[n]+=2, s_read=0, last_served=n, go to IDLE. No new request is issued in the same cycle, so at least one idle cycle falls between requests.
  - s_enable falling during WAIT: the outstanding read completes normally; no new request starts.
  - Trigger of channel n while n is in WAIT: the returned data is discarded. need[n] stays 1 and ptr[n] restarts at CH_BASE[n].
- End of sample: when the post-increment ptr[n] equals CH_BASE[n]+CH_LEN[n]:
  - If LOOP_MASK[n] & trig[n]: ptr[n]=CH_BASE[n].
  - Otherwise: active[n]=0, need[n]=0.
  - The final word still plays for one tick. The stop takes effect from the following tick, when sample[n] is forced to 0.
- Mix:
  - Left = signed sum of sample[n] for active n with PAN_L[n]; right likewise with PAN_R.
  - Accumulator is 16+clog2(NUM_CH) bits, saturated to [-32768, 32767].
  - Outputs update only on ENA. Inactive channels contribute 0.

Test Plan:
- Reset mid-fetch (s_read=1), then release I_RESET → s_read=0, outputs 0, no s_ready needed; next trigger restarts cleanly.
- Write 8'h01 to PORT_ADDR, memory returns 16'h1000 for the CH_BASE[0] word, ENA every 64 clocks → s_addr=CH_BASE[0], then +2. audio_out_l = audio_out_r = 16'h1000 after the tick following the fetch. Active drops after CH_LEN/2 words.
- Trigger all 4 channels at once, s_ready delayed 3 cycles → grants in order 0,1,2,3 with an idle cycle between each; no underrun.
- Four channels each returning 16'h7000, NUM_CH=4 → outputs saturate to 16'h7FFF. With all samples 16'h9000, outputs = 16'h8000.
- Channel 1 in LOOP_MASK, trigger bit held → after the last word, s_addr returns to CH_BASE[1]. Clear the bit → the channel stops at its next end; the mix returns to 0.
- Hold s_ready low across two ENA ticks → underrun[n]=1 sticky and the sample is repeated; retriggering the channel clears the flag.
